// File: rtl/cpu16_pkg.sv
// Shared op-codes, width and flag record for the cpu16 ALU.
// ICNT is one-hot; any other nonzero code is illegal.
package cpu16_pkg;

   localparam int DATA_W = 16;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b1000;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } flags_t;

endpackage

// File: rtl/cpu16_alu_core.sv
// Combinational ALU datapath: result, flags and op legality from A, B, ICNT.
// Illegal codes produce the cleared result (0 with only Z set).
module cpu16_alu_core
   import cpu16_pkg::*;
#(
   parameter int DATA_W = cpu16_pkg::DATA_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        icnt,
   output logic [DATA_W-1:0] result,
   output flags_t            flags,
   output logic              legal
);

   logic signed [DATA_W-1:0] a_s;
   logic signed [DATA_W-1:0] b_s;
   logic [DATA_W:0]          sum;
   logic [DATA_W:0]          diff;

   assign a_s  = $signed(a);
   assign b_s  = $signed(b);
   // The extra top bit carries out of ADD and becomes the borrow for SUB.
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      result  = '0;
      flags.c = 1'b0;
      flags.v = 1'b0;
      legal   = 1'b1;
      case (icnt)
         OP_ADD: begin
            result  = sum[DATA_W-1:0];
            flags.c = sum[DATA_W];
            flags.v = (a_s[DATA_W-1] == b_s[DATA_W-1]) && (sum[DATA_W-1] != a_s[DATA_W-1]);
         end
         OP_SUB: begin
            result  = diff[DATA_W-1:0];
            flags.c = diff[DATA_W];
            flags.v = (a_s[DATA_W-1] != b_s[DATA_W-1]) && (diff[DATA_W-1] != a_s[DATA_W-1]);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         default: legal = 1'b0;
      endcase
      flags.z = (result == '0);
      flags.n = result[DATA_W-1];
   end

endmodule

// File: rtl/cpu16_alu.sv
// Single-cycle registered ALU: wraps cpu16_alu_core with result/flag registers.
// NOP holds the last result and flags; illegal codes clear them and raise err.
module cpu16_alu
   import cpu16_pkg::*;
#(
   parameter int DATA_W = cpu16_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        icnt,
   output logic [DATA_W-1:0] out,
   output logic              out_valid,
   output logic              zf,
   output logic              nf,
   output logic              cf,
   output logic              vf,
   output logic              err
);

   logic [DATA_W-1:0] res_p0;
   flags_t            flags_p0;
   logic              legal_p0;

   logic [DATA_W-1:0] out_p1;
   flags_t            flags_p1;
   logic              vld_p1;
   logic              err_p1;

   cpu16_alu_core #(.DATA_W(DATA_W)) u_core (
      .a      (a),
      .b      (b),
      .icnt   (icnt),
      .result (res_p0),
      .flags  (flags_p0),
      .legal  (legal_p0)
   );

   // p0 -> p1: register result and flags; reset clears data as well as control
   always_ff @(posedge clk) begin
      if (rst) begin
         out_p1   <= '0;
         flags_p1 <= '{z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0};
         vld_p1   <= 1'b0;
         err_p1   <= 1'b0;
      end else if (icnt != OP_NOP) begin
         out_p1   <= res_p0;
         flags_p1 <= flags_p0;
         vld_p1   <= legal_p0;
         err_p1   <= ~legal_p0;
      end else begin
         vld_p1   <= 1'b0;
         err_p1   <= 1'b0;
      end
   end

   assign out       = out_p1;
   assign zf        = flags_p1.z;
   assign nf        = flags_p1.n;
   assign cf        = flags_p1.c;
   assign vf        = flags_p1.v;
   assign out_valid = vld_p1;
   assign err       = err_p1;

endmodule

// File: tb/tb_cpu16_alu.sv
// Directed vector bench for cpu16_alu: a stateful table of ops with expected
// registered outputs, followed by a short hand-written reset/back-to-back sequence.
module tb_cpu16_alu;

   typedef struct {
      logic        rst;
      logic [3:0]  icnt;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] out;
      logic [5:0]  flg;   // {zf, nf, cf, vf, out_valid, err}
   } vec_t;

   localparam int NVEC = 22;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] a;
   logic [15:0] b;
   logic [3:0]  icnt;
   logic [15:0] out;
   logic        out_valid, zf, nf, cf, vf, err;

   int n_vec  = 0;
   int n_miss = 0;

   vec_t tbl [NVEC];

   cpu16_alu #(.DATA_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .icnt      (icnt),
      .out       (out),
      .out_valid (out_valid),
      .zf        (zf),
      .nf        (nf),
      .cf        (cf),
      .vf        (vf),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic step(input logic r, input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb);
      @(negedge clk);
      rst  = r;
      icnt = op;
      a    = va;
      b    = vb;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] eout, input logic [5:0] eflg);
      logic [5:0] got;
      got = {zf, nf, cf, vf, out_valid, err};
      n_vec++;
      if (out !== eout || got !== eflg) begin
         n_miss++;
         $display("FAIL %s: got out=%h zncv_vld_err=%b, want out=%h zncv_vld_err=%b",
                  name, out, got, eout, eflg);
      end
   endtask

   initial begin
      //         rst   icnt     a         b         out       z n c v vld err
      tbl[0]  = '{1'b1, 4'b0001, 16'h0005, 16'h0005, 16'h0000, 6'b1000_00};
      tbl[1]  = '{1'b0, 4'b0001, 16'h0005, 16'h0005, 16'h000A, 6'b0000_10};
      tbl[2]  = '{1'b0, 4'b0001, 16'h0001, 16'h000A, 16'h000B, 6'b0000_10};
      tbl[3]  = '{1'b0, 4'b0000, 16'h1234, 16'h4321, 16'h000B, 6'b0000_00};
      tbl[4]  = '{1'b0, 4'b0010, 16'h000A, 16'h0001, 16'h0009, 6'b0000_10};
      tbl[5]  = '{1'b0, 4'b0010, 16'h0001, 16'h000A, 16'hFFF7, 6'b0110_10};
      tbl[6]  = '{1'b0, 4'b0000, 16'h0000, 16'h0000, 16'hFFF7, 6'b0110_00};
      tbl[7]  = '{1'b0, 4'b0100, 16'h000C, 16'h000A, 16'h0008, 6'b0000_10};
      tbl[8]  = '{1'b0, 4'b1000, 16'h000C, 16'h000A, 16'h000E, 6'b0000_10};
      tbl[9]  = '{1'b0, 4'b0001, 16'hFFFF, 16'h0001, 16'h0000, 6'b1010_10};
      tbl[10] = '{1'b0, 4'b0001, 16'h7FFF, 16'h0001, 16'h8000, 6'b0101_10};
      tbl[11] = '{1'b0, 4'b0011, 16'h7FFF, 16'h0001, 16'h0000, 6'b1000_01};
      tbl[12] = '{1'b0, 4'b0000, 16'hFFFF, 16'hFFFF, 16'h0000, 6'b1000_00};
      tbl[13] = '{1'b0, 4'b0010, 16'h8000, 16'h0001, 16'h7FFF, 6'b0001_10};
      tbl[14] = '{1'b0, 4'b1111, 16'hAAAA, 16'h5555, 16'h0000, 6'b1000_01};
      tbl[15] = '{1'b0, 4'b0010, 16'h0005, 16'h0005, 16'h0000, 6'b1000_10};
      tbl[16] = '{1'b0, 4'b0001, 16'h8000, 16'h8000, 16'h0000, 6'b1011_10};
      tbl[17] = '{1'b0, 4'b0100, 16'hFFFF, 16'h0000, 16'h0000, 6'b1000_10};
      tbl[18] = '{1'b0, 4'b1000, 16'h8000, 16'h0001, 16'h8001, 6'b0100_10};
      tbl[19] = '{1'b0, 4'b0101, 16'h1111, 16'h2222, 16'h0000, 6'b1000_01};
      tbl[20] = '{1'b1, 4'b0010, 16'h0001, 16'h000A, 16'h0000, 6'b1000_00};
      tbl[21] = '{1'b0, 4'b0000, 16'h0001, 16'h000A, 16'h0000, 6'b1000_00};

      rst = 1'b1; icnt = 4'b0000; a = '0; b = '0;

      for (int i = 0; i < NVEC; i++) begin
         step(tbl[i].rst, tbl[i].icnt, tbl[i].a, tbl[i].b);
         check($sformatf("vec%0d", i), tbl[i].out, tbl[i].flg);
      end

      // Back-to-back ops, reset mid-stream discarding an op, then immediate resume.
      step(1'b0, 4'b0001, 16'h1234, 16'h1111);
      check("b2b_add", 16'h2345, 6'b0000_10);
      step(1'b0, 4'b1000, 16'hF000, 16'h000F);
      check("b2b_or", 16'hF00F, 6'b0100_10);
      step(1'b1, 4'b0001, 16'hFFFF, 16'hFFFF);
      check("rst_discard", 16'h0000, 6'b1000_00);
      step(1'b0, 4'b0010, 16'h0001, 16'h0002);
      check("post_rst_sub", 16'hFFFF, 6'b0110_10);
      step(1'b0, 4'b0000, 16'h0000, 16'h0000);
      check("nop_hold1", 16'hFFFF, 6'b0110_00);
      step(1'b0, 4'b0000, 16'h5555, 16'hAAAA);
      check("nop_hold2", 16'hFFFF, 6'b0110_00);
      step(1'b0, 4'b1100, 16'h5555, 16'hAAAA);
      check("illegal_hi", 16'h0000, 6'b1000_01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
